prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter NUM_INSTR, default 8, giving the number of instruction words per load session.
REQ-002 The block SHALL have parameter NIB_W, default 4, giving the width of one stream beat in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, which begins or restarts a load session.
REQ-006 The block SHALL have port in_valid, input, 1 bit, indicating that the in_nib beat is valid.
REQ-007 The block SHALL have port in_nib, input, 4 bits, the stream beat, MSB-first nibble of an instruction.
REQ-008 The block SHALL have port in_ready, output, 1 bit; a beat transfers when in_valid && in_ready.
REQ-009 The block SHALL have port wr_en, output, 1 bit, a one-cycle program-store write strobe.
REQ-010 The block SHALL have port wr_addr, output, 3 bits, the program-store address.
REQ-011 The block SHALL have port wr_data, output, 12 bits [0:11] with bit 0 as MSB: opcode [0:2], src1 [3:5], src2 [6:8], dest [9:11].
REQ-012 The block SHALL have port cpu_hold, output, 1 bit, which stalls the processor while no verified program is present.
REQ-013 The block SHALL have port load_done, output, 1 bit, a level indicating a verified program is loaded.
REQ-014 The block SHALL have port err_csum, output, 1 bit, a sticky checksum-mismatch flag.
REQ-015 The block SHALL have port err_opcode, output, 1 bit, a sticky flag indicating an opcode > 3 was received.

Function
REQ-016 The state machine SHALL have the states IDLE, RECV, CHECK, DONE and ERR.
REQ-017 in_ready SHALL be 1 only in RECV and CHECK; beats offered in IDLE, DONE or ERR SHALL be ignored.
REQ-018 start in any state SHALL clear the beat counter, instruction counter, checksum accumulator, err_csum, err_opcode and load_done, set cpu_hold=1, and enter RECV on the next cycle; a beat offered in the same cycle as start SHALL NOT be accepted.
REQ-019 In RECV, each accepted beat SHALL be shifted into the 12-bit assembler MSB-first (3 beats per instruction) and XORed into a 4-bit checksum.
REQ-020 The cycle after the 3rd beat of an instruction is accepted, the block SHALL drive wr_en=1 for exactly one cycle, with wr_addr = instruction index (0..7) and wr_data = the assembled word.
REQ-021 Acceptance of the next beat SHALL continue during the wr_en cycle with no stall cycles.
REQ-022 If an assembled opcode wr_data[0:2] is greater than 3, the block SHALL set err_opcode=1 and still perform the write.
REQ-023 After NUM_INSTR*3 beats the block SHALL enter CHECK; the next accepted beat is the checksum and SHALL NOT be written to the program store.
REQ-024 In CHECK, if the checksum beat equals the accumulator and err_opcode=0, the block SHALL enter DONE with load_done=1 and cpu_hold=0; otherwise it SHALL enter ERR, setting err_csum=1 if the checksum mismatched, with cpu_hold remaining 1.
REQ-025 DONE and ERR SHALL hold until start or reset.
REQ-026 The instruction index SHALL never exceed NUM_INSTR-1; there SHALL be no wrap-around writes.
REQ-027 in_valid deasserted mid-instruction SHALL preserve the partial word indefinitely.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, load_done=0, err_csum=0, err_opcode=0, and all counters and the checksum to 0.
REQ-029 A reset mid-session SHALL abandon the session; a session SHALL be restarted only by a new start.

Structure
REQ-030 A shared package prog_loader_pkg SHALL hold the opcode constants ADD=0, JMP=1, AND=2, XOR=3, INSTR_W=12, PROG_ADDR_W=3, and the state enum.
REQ-031 A single sub-module nibble_packer SHALL perform the shift-assembly and checksum accumulation; the FSM, counters and write strobe SHALL reside in prog_loader.

Verification
REQ-032 Bench scenario (nominal load): start, then beats 2,4,0, 4,8,0, 6,C,0, 0,0,0, 1,F,9, then 9 zeros, then checksum 7 -> eight wr_en pulses at addr 0..7 with data 0x240,0x480,0x6C0,0x000,0x1F9,0,0,0; load_done=1; cpu_hold=0.
REQ-033 Bench scenario (bad checksum): same stream with checksum 8 -> err_csum=1, state ERR, cpu_hold=1, load_done=0.
REQ-034 Bench scenario (illegal opcode): slot 3 = 9,0,0 (0x900) with checksum E -> err_opcode=1, err_csum=0, ERR, cpu_hold=1, and addr 3 still written with 0x900.
REQ-035 Bench scenario (throttled input): the nominal stream with in_valid toggling 1/0 each cycle -> identical write sequence, no duplicate writes.
REQ-036 Bench scenario (restart): start reasserted after 10 beats -> the next write is at addr 0 with the new data, and the checksum covers only post-restart beats.
REQ-037 Bench scenario (reset mid-load): rst_n=0 after 7 beats -> outputs reach reset values without waiting for a clock edge; beats are ignored until the next start.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants, state encoding and opcode helper for the program loader.
package prog_loader_pkg;

  localparam int INSTR_W     = 12;
  localparam int PROG_ADDR_W = 3;
  localparam int OPC_W       = 3;

  // Legal opcodes; anything above XOR is rejected.
  localparam logic [OPC_W-1:0] ADD = 3'd0;
  localparam logic [OPC_W-1:0] JMP = 3'd1;
  localparam logic [OPC_W-1:0] AND = 3'd2;
  localparam logic [OPC_W-1:0] XOR = 3'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // True when the opcode field (top bits, word bit 0 side) is not a legal opcode.
  function automatic logic opcode_illegal(input logic [INSTR_W-1:0] word);
    logic [OPC_W-1:0] opc;
    opc = word[INSTR_W-1 -: OPC_W];
    return (opc > XOR);
  endfunction

endpackage

// File: rtl/prog_loader_nibble_packer.sv
// Shift-assembles MSB-first beats into instruction words and keeps the
// running XOR checksum of every beat shifted in.
module nibble_packer
  import prog_loader_pkg::*;
#(
  parameter int NIB_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [NIB_W-1:0]   nib_i,
  output logic [INSTR_W-1:0] word_next_o,
  output logic [NIB_W-1:0]   csum_o
);

  // Only the earlier beats of a word need storing; the final beat is
  // combined on the fly so the completed word is visible on its accept edge.
  logic [INSTR_W-NIB_W-1:0] word_q;
  logic [NIB_W-1:0]         csum_q;

  assign word_next_o = {word_q, nib_i};
  assign csum_o      = csum_q;

  // Partial-word shift register and checksum; hold when no beat is shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      csum_q <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      csum_q <= '0;
    end else if (shift_i) begin
      word_q <= word_next_o[INSTR_W-NIB_W-1:0];
      csum_q <= csum_q ^ nib_i;
    end else begin
      word_q <= word_q;
      csum_q <= csum_q;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a nibble stream, writes instruction words into
// the program store and releases the CPU only after a verified load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int NUM_INSTR = 8,
  parameter int NIB_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [NIB_W-1:0]       in_nib,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [PROG_ADDR_W-1:0] wr_addr,
  output logic [0:INSTR_W-1]     wr_data,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   err_csum,
  output logic                   err_opcode
);

  localparam int BEATS = INSTR_W / NIB_W;
  localparam logic [1:0]             LAST_BEAT = 2'(BEATS - 1);
  localparam logic [PROG_ADDR_W-1:0] LAST_IDX  = PROG_ADDR_W'(NUM_INSTR - 1);

  state_e                 state_q;
  logic [1:0]             beat_cnt_q;
  logic [PROG_ADDR_W-1:0] instr_cnt_q;
  logic                   in_ready_q;
  logic                   wr_en_q;
  logic [PROG_ADDR_W-1:0] wr_addr_q;
  logic [INSTR_W-1:0]     wr_data_q;
  logic                   cpu_hold_q;
  logic                   load_done_q;
  logic                   err_csum_q;
  logic                   err_opcode_q;

  logic                   accept_s;
  logic                   shift_s;
  logic [INSTR_W-1:0]     word_next_s;
  logic [NIB_W-1:0]       csum_s;

  // A beat offered together with start is never taken.
  assign accept_s = in_valid && in_ready_q && !start;
  assign shift_s  = accept_s && (state_q == RECV);

  nibble_packer #(
    .NIB_W (NIB_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start),
    .shift_i     (shift_s),
    .nib_i       (in_nib),
    .word_next_o (word_next_s),
    .csum_o      (csum_s)
  );

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign err_csum   = err_csum_q;
  assign err_opcode = err_opcode_q;

  // Load session FSM with counters, write strobe and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 2'd0;
      instr_cnt_q  <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      err_csum_q   <= 1'b0;
      err_opcode_q <= 1'b0;
    end else if (start) begin
      state_q      <= RECV;
      beat_cnt_q   <= 2'd0;
      instr_cnt_q  <= '0;
      in_ready_q   <= 1'b1;
      wr_en_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      err_csum_q   <= 1'b0;
      err_opcode_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b0;
        end
        RECV: begin
          if (accept_s) begin
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q <= 2'd0;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= instr_cnt_q;
              wr_data_q  <= word_next_s;
              if (opcode_illegal(word_next_s)) begin
                err_opcode_q <= 1'b1;
              end else begin
                err_opcode_q <= err_opcode_q;
              end
              // The index saturates at the last slot; the next beat is the checksum.
              if (instr_cnt_q == LAST_IDX) begin
                state_q <= CHECK;
              end else begin
                instr_cnt_q <= instr_cnt_q + PROG_ADDR_W'(1);
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 2'd1;
            end
          end else begin
            beat_cnt_q <= beat_cnt_q;
          end
        end
        CHECK: begin
          if (accept_s) begin
            in_ready_q <= 1'b0;
            if ((in_nib == csum_s) && !err_opcode_q) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              state_q    <= ERR;
              err_csum_q <= (in_nib != csum_s);
              cpu_hold_q <= 1'b1;
            end
          end else begin
            state_q <= CHECK;
          end
        end
        DONE: begin
          in_ready_q <= 1'b0;
        end
        ERR: begin
          in_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
